// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, assembles 11-bit frames
// and decodes Set 2 (US) scan codes into ASCII keypress pulses.
module ps2_keyboard #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_out,
    output logic       p_valid,
    output logic       shift_on,
    output logic       caps_on,
    output logic       frame_err
);
    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

    logic        r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic [1:0]  r_clk_hist;
    logic        w_fall;
    logic [10:0] r_shift;
    logic [3:0]  r_bitcnt;
    logic [15:0] r_to_cnt;
    logic        r_done_p1;
    logic [7:0]  w_byte;
    logic        w_frame_ok;
    state_t      r_state, w_state_nx;
    logic        r_lshift, r_rshift, w_lshift_nx, w_rshift_nx, w_caps_nx;
    logic [7:0]  w_key_nx, w_ascii;
    logic        w_pv_nx, w_ferr_nx, w_mapped, w_letter;

    // Stage p0: synchronizers and falling-edge detect on a 1,1,0 history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_hist <= 2'b11;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_hist <= {r_clk_hist[0], r_clk_sync};
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall = r_clk_hist[1] & r_clk_hist[0] & ~r_clk_sync;

    // Stage p1: frame assembly; bits enter at the MSB so the start bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_to_cnt  <= '0;
            r_done_p1 <= 1'b0;
        end else begin
            r_done_p1 <= 1'b0;
            if (w_fall) begin
                r_shift  <= {r_dat_sync, r_shift[10:1]};
                r_to_cnt <= '0;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt  <= '0;
                    r_done_p1 <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_to_cnt == TIMEOUT_CYCLES - 16'd1) begin
                    r_bitcnt <= '0;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign w_byte     = r_shift[8:1];
    assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
    assign shift_on   = r_lshift | r_rshift;

    always_comb begin
        w_ascii  = 8'h00;
        w_mapped = 1'b1;
        w_letter = 1'b0;
        case (w_byte)
            8'h1C: w_ascii = 8'h61;  8'h32: w_ascii = 8'h62;  8'h21: w_ascii = 8'h63;
            8'h23: w_ascii = 8'h64;  8'h24: w_ascii = 8'h65;  8'h2B: w_ascii = 8'h66;
            8'h34: w_ascii = 8'h67;  8'h33: w_ascii = 8'h68;  8'h43: w_ascii = 8'h69;
            8'h3B: w_ascii = 8'h6A;  8'h42: w_ascii = 8'h6B;  8'h4B: w_ascii = 8'h6C;
            8'h3A: w_ascii = 8'h6D;  8'h31: w_ascii = 8'h6E;  8'h44: w_ascii = 8'h6F;
            8'h4D: w_ascii = 8'h70;  8'h15: w_ascii = 8'h71;  8'h2D: w_ascii = 8'h72;
            8'h1B: w_ascii = 8'h73;  8'h2C: w_ascii = 8'h74;  8'h3C: w_ascii = 8'h75;
            8'h2A: w_ascii = 8'h76;  8'h1D: w_ascii = 8'h77;  8'h22: w_ascii = 8'h78;
            8'h35: w_ascii = 8'h79;  8'h1A: w_ascii = 8'h7A;
            8'h45: w_ascii = shift_on ? 8'h29 : 8'h30;
            8'h16: w_ascii = shift_on ? 8'h21 : 8'h31;
            8'h1E: w_ascii = shift_on ? 8'h40 : 8'h32;
            8'h26: w_ascii = shift_on ? 8'h23 : 8'h33;
            8'h25: w_ascii = shift_on ? 8'h24 : 8'h34;
            8'h2E: w_ascii = shift_on ? 8'h25 : 8'h35;
            8'h36: w_ascii = shift_on ? 8'h5E : 8'h36;
            8'h3D: w_ascii = shift_on ? 8'h26 : 8'h37;
            8'h3E: w_ascii = shift_on ? 8'h2A : 8'h38;
            8'h46: w_ascii = shift_on ? 8'h28 : 8'h39;
            8'h29: w_ascii = 8'h20;
            8'h5A: w_ascii = 8'h0A;
            8'h66: w_ascii = 8'h08;
            default: w_mapped = 1'b0;
        endcase
        if (w_ascii >= 8'h61 && w_ascii <= 8'h7A) begin
            w_letter = 1'b1;
        end
        if (w_letter && (shift_on ^ caps_on)) begin
            w_ascii = w_ascii - 8'h20;
        end
    end

    // Stage p2: scan-code decoder; all outputs registered here.
    always_comb begin
        w_state_nx  = r_state;
        w_lshift_nx = r_lshift;
        w_rshift_nx = r_rshift;
        w_caps_nx   = caps_on;
        w_key_nx    = key_out;
        w_pv_nx     = 1'b0;
        w_ferr_nx   = 1'b0;
        if (r_done_p1 && !w_frame_ok) begin
            w_ferr_nx  = 1'b1;
            w_state_nx = S_IDLE;
        end else if (r_done_p1) begin
            w_state_nx = S_IDLE;
            case (r_state)
                S_IDLE: begin
                    if (w_byte == 8'hF0)      w_state_nx  = S_BREAK;
                    else if (w_byte == 8'hE0) w_state_nx  = S_EXT;
                    else if (w_byte == 8'h12) w_lshift_nx = 1'b1;
                    else if (w_byte == 8'h59) w_rshift_nx = 1'b1;
                    else if (w_byte == 8'h58) w_caps_nx   = ~caps_on;
                    else if (w_mapped) begin
                        w_key_nx = w_ascii;
                        w_pv_nx  = 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_byte == 8'h12)      w_lshift_nx = 1'b0;
                    else if (w_byte == 8'h59) w_rshift_nx = 1'b0;
                end
                S_EXT: begin
                    if (w_byte == 8'hF0) begin
                        w_state_nx = S_EXT_BREAK;
                    end else if (w_byte == 8'h5A) begin
                        w_key_nx = 8'h0A;
                        w_pv_nx  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_lshift  <= 1'b0;
            r_rshift  <= 1'b0;
            caps_on   <= 1'b0;
            key_out   <= 8'h00;
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_lshift  <= w_lshift_nx;
            r_rshift  <= w_rshift_nx;
            caps_on   <= w_caps_nx;
            key_out   <= w_key_nx;
            p_valid   <= w_pv_nx;
            frame_err <= w_ferr_nx;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: frame-level reference model with a per-cycle output compare,
// directed keypress scenarios pinned by literals, then randomized scan-code traffic.
module tb_ps2_keyboard;
    localparam logic [15:0] TO = 16'd300;

    logic       clk, reset, ps2_clk, ps2_data;
    logic [7:0] key_out;
    logic       p_valid, shift_on, caps_on, frame_err;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_out(key_out), .p_valid(p_valid), .shift_on(shift_on),
        .caps_on(caps_on), .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        bit         pv;
        bit         fe;
        logic [7:0] key;
        bit         sh;
        bit         caps;
    } exp_t;
    exp_t q[$];

    logic [7:0] LET [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                             8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                             8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] DIG [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] SYM [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};
    logic [7:0] EXTRA [8] = '{8'h29,8'h5A,8'h66,8'h05,8'h0D,8'h76,8'h7C,8'h11};

    // Reference model state: partial frame and decoder context.
    logic [10:0] m_bits;
    int          m_n = 0;
    int          m_last = 0;
    int          m_state = 0;   // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
    bit          m_ls = 0, m_rs = 0, m_caps = 0;
    logic [7:0]  m_key = 8'h00;

    logic [7:0] obs[$];
    int         obs_cyc[$];
    int         fe_cnt = 0;

    function automatic void model_map(input logic [7:0] c, output bit hit, output logic [7:0] a);
        bit sh;
        sh  = m_ls | m_rs;
        hit = 1'b0;
        a   = 8'h00;
        for (int i = 0; i < 26; i++)
            if (LET[i] == c) begin
                hit = 1'b1;
                a   = ((sh ^ m_caps) ? 8'h41 : 8'h61) + i[7:0];
            end
        for (int i = 0; i < 10; i++)
            if (DIG[i] == c) begin
                hit = 1'b1;
                a   = sh ? SYM[i] : 8'h30 + i[7:0];
            end
        if (c == 8'h29) begin hit = 1'b1; a = 8'h20; end
        if (c == 8'h5A) begin hit = 1'b1; a = 8'h0A; end
        if (c == 8'h66) begin hit = 1'b1; a = 8'h08; end
    endfunction

    function automatic void model_frame(input int at);
        exp_t       e;
        bit         ok, hit;
        logic [7:0] b, a;
        ok = (m_bits[0] == 1'b0) && (m_bits[10] == 1'b1) && ((^m_bits[9:1]) == 1'b1);
        b  = m_bits[8:1];
        e.pv = 1'b0;
        e.fe = 1'b0;
        if (!ok) begin
            e.fe    = 1'b1;
            m_state = 0;
        end else begin
            case (m_state)
                0: begin
                    m_state = 0;
                    if (b == 8'hF0) m_state = 1;
                    else if (b == 8'hE0) m_state = 2;
                    else if (b == 8'h12) m_ls = 1'b1;
                    else if (b == 8'h59) m_rs = 1'b1;
                    else if (b == 8'h58) m_caps = ~m_caps;
                    else begin
                        model_map(b, hit, a);
                        if (hit) begin m_key = a; e.pv = 1'b1; end
                    end
                end
                1: begin
                    if (b == 8'h12) m_ls = 1'b0;
                    if (b == 8'h59) m_rs = 1'b0;
                    m_state = 0;
                end
                2: begin
                    m_state = (b == 8'hF0) ? 3 : 0;
                    if (b == 8'h5A) begin m_key = 8'h0A; e.pv = 1'b1; end
                end
                default: m_state = 0;
            endcase
        end
        e.cyc  = at;
        e.key  = m_key;
        e.sh   = m_ls | m_rs;
        e.caps = m_caps;
        q.push_back(e);
    endfunction

    function automatic void model_edge(input bit d);
        if (m_n > 0 && (cyc - m_last) > int'(TO)) m_n = 0;
        m_bits[m_n] = d;
        m_n++;
        m_last = cyc;
        if (m_n == 11) begin
            m_n = 0;
            model_frame(cyc + 4);
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input int nbits,
                              input bit bad_start, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f[0]   = bad_start;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            model_edge(f[i]);
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        m_n = 0; m_state = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_key = 8'h00;
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic clear_obs();
        obs.delete();
        obs_cyc.delete();
        fe_cnt = 0;
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        exp_t       e;
        bit         x_pv, x_fe, x_sh, x_caps;
        logic [7:0] x_key;
        x_pv = 0; x_fe = 0; x_sh = 0; x_caps = 0; x_key = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            x_pv = 1'b0;
            x_fe = 1'b0;
            if (!reset) begin
                x_sh = 1'b0; x_caps = 1'b0; x_key = 8'h00;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++; errors++;
                    $display("FAIL missed_event cyc=%0d due=%0d", cyc, e.cyc);
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    x_pv = e.pv; x_fe = e.fe; x_key = e.key; x_sh = e.sh; x_caps = e.caps;
                end
            end
            checks++;
            if (p_valid !== x_pv || frame_err !== x_fe || key_out !== x_key ||
                shift_on !== x_sh || caps_on !== x_caps) begin
                errors++;
                $display("FAIL cmp cyc=%0d pv=%0b/%0b fe=%0b/%0b key=%02h/%02h sh=%0b/%0b caps=%0b/%0b (got/want)",
                         cyc, p_valid, x_pv, frame_err, x_fe, key_out, x_key,
                         shift_on, x_sh, caps_on, x_caps);
            end
            if (p_valid) begin
                obs.push_back(key_out);
                obs_cyc.push_back(cyc);
            end
            if (frame_err) fe_cnt++;
        end
    end

    initial begin
        int t_a, r, nb;
        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_key", key_out, 8'h00);
        chk("rst_status", {p_valid, shift_on, caps_on, frame_err}, 0);
        do_reset();

        clear_obs();
        key(8'h1C); t_a = m_last;
        key(8'hF0); key(8'h1C); settle();
        chk("a_count", obs.size(), 1);
        if (obs.size() > 0) begin
            chk("a_key", obs[0], 8'h61);
            chk("a_latency", obs_cyc[0] - t_a, 4);
        end

        clear_obs();
        key(8'h1C); key(8'h1C); key(8'h1C); settle();
        chk("typematic_count", obs.size(), 3);

        clear_obs();
        key(8'h12); settle();
        chk("shift_held", shift_on, 1);
        key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C); settle();
        chk("shift_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("shift_k0", obs[0], 8'h41);
            chk("shift_k1", obs[1], 8'h61);
        end
        chk("shift_released", shift_on, 0);

        clear_obs();
        key(8'h58); key(8'hF0); key(8'h58); key(8'h1C); key(8'h12); key(8'h1C); settle();
        chk("caps_on", caps_on, 1);
        chk("caps_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("caps_k0", obs[0], 8'h41);
            chk("caps_k1", obs[1], 8'h61);
        end

        do_reset();
        clear_obs();
        send_frame(8'h16, 11, 1'b0, 1'b1, 1'b0); settle();
        chk("par_err_pulses", fe_cnt, 1);
        chk("par_err_nokey", obs.size(), 0);
        key(8'h5A); settle();
        chk("enter_key", obs.size() == 1 ? int'(obs[0]) : -1, 8'h0A);

        clear_obs();
        send_frame(8'h1C, 5, 1'b0, 1'b0, 1'b0);
        repeat (int'(TO) + 1) @(negedge clk);
        key(8'h29); settle();
        chk("timeout_key", obs.size() == 1 ? int'(obs[0]) : -1, 8'h20);
        chk("timeout_noerr", fe_cnt, 0);

        clear_obs();
        send_frame(8'h1C, 6, 1'b0, 1'b0, 1'b0);
        do_reset();
        key(8'h45); settle();
        chk("rst_mid_key", obs.size() == 1 ? int'(obs[0]) : -1, 8'h30);
        chk("rst_mid_status", {shift_on, caps_on, frame_err}, 0);
        chk("rst_mid_noerr", fe_cnt, 0);

        for (int n = 0; n < 200; n++) begin
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 12)      b = 8'hF0;
            else if (r < 18) b = 8'hE0;
            else if (r < 24) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else if (r < 27) b = 8'h58;
            else if (r < 55) b = LET[$urandom_range(0, 25)];
            else if (r < 80) b = DIG[$urandom_range(0, 9)];
            else             b = EXTRA[$urandom_range(0, 7)];
            r = $urandom_range(0, 99);
            if (r < 6)       send_frame(b, 11, 1'b0, 1'b1, 1'b0);
            else if (r < 9)  send_frame(b, 11, 1'b0, 1'b0, 1'b1);
            else if (r < 11) send_frame(b, 11, 1'b1, 1'b0, 1'b0);
            else if (r < 14) begin
                nb = $urandom_range(1, 10);
                send_frame(b, nb, 1'b0, 1'b0, 1'b0);
                repeat (int'(TO) + 40) @(negedge clk);
            end else if (r < 16) do_reset();
            else key(b);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (50) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
